// File: rtl/uart_hex_line_tx.sv
// uart_hex_line_tx: reports a word as an uppercase hex ASCII line (MSB first, then CR LF)
// by driving the byte handshake of a uart_tx serializer one character at a time.
module uart_hex_line_tx #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value,
   input  logic              value_valid,
   output logic              ready,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              line_done,
   output logic [15:0]       drop_cnt
);
   localparam int NIBBLES  = DATA_W / 4;
   localparam int LINE_LEN = NIBBLES + 2;
   localparam int IW       = $clog2(LINE_LEN);
   localparam logic [IW-1:0] IDX_LAST_NIB = IW'(NIBBLES - 1);
   localparam logic [IW-1:0] IDX_CR       = IW'(NIBBLES);
   localparam logic [IW-1:0] IDX_LAST     = IW'(LINE_LEN - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic              line_done_q, line_done_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [3:0]        nib;
   logic [7:0]        cur_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

   // Digit idx is taken by shifting the wanted nibble down to the bottom; the
   // wrapped shift amount for idx past the digits is never used (CR/LF win).
   always_comb begin
      nib = 4'(shadow_q >> {IDX_LAST_NIB - idx_q, 2'b00});
      if (idx_q == IDX_CR)        cur_char = 8'h0D;
      else if (idx_q == IDX_LAST) cur_char = 8'h0A;
      else                        cur_char = hex_ascii(nib);
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      line_done_d = 1'b0;
      drop_cnt_d  = drop_cnt_q;

      if (value_valid && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (value_valid) begin
               shadow_d = value;
               idx_d    = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (!tx_busy) begin
               tx_data_d  = cur_char;
               tx_start_d = 1'b1;
               state_d    = WAIT_HI;
            end
         end
         // Busy must be seen high first so a late-registered start is not mistaken for completion.
         WAIT_HI: begin
            if (tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == IDX_LAST) begin
                  line_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         shadow_q    <= '0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         line_done_q <= 1'b0;
         drop_cnt_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         line_done_q <= line_done_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign line_done = line_done_q;
   assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_uart_hex_line_tx.sv
// Bench for uart_hex_line_tx: 32-bit and 8-bit instances against a uart_tx stand-in
// (busy for 3 cycles after each start) and a line-level model of the expected bytes.
module tb_uart_hex_line_tx;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic        value_valid;
   logic        ready, tx_start, tx_busy, line_done;
   logic [7:0]  tx_data;
   logic [15:0] drop_cnt;

   logic [7:0]  value8;
   logic        value_valid8;
   logic        ready8, tx_start8, tx_busy8, line_done8;
   logic [7:0]  tx_data8;
   logic [15:0] drop_cnt8;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  cap[$];
   logic [7:0]  cap8[$];
   logic [15:0] model_drop = 16'h0;
   int          ld_seen = 0;
   int          ld8_seen = 0;
   bit          prev_start = 1'b0;
   int          busy_cnt = 0;
   int          busy_cnt8 = 0;
   logic        hold_busy = 1'b0;
   logic [7:0]  L1 [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};

   always #5 clk = ~clk;

   uart_hex_line_tx #(.DATA_W(32)) u_dut (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .ready(ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .line_done(line_done),
      .drop_cnt(drop_cnt));

   uart_hex_line_tx #(.DATA_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .value(value8), .value_valid(value_valid8), .ready(ready8),
      .tx_data(tx_data8), .tx_start(tx_start8), .tx_busy(tx_busy8), .line_done(line_done8),
      .drop_cnt(drop_cnt8));

   // uart_tx stand-ins
   always @(posedge clk) begin
      if (tx_start && busy_cnt == 0) busy_cnt <= 3;
      else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
      if (tx_start8 && busy_cnt8 == 0) busy_cnt8 <= 3;
      else if (busy_cnt8 > 0)          busy_cnt8 <= busy_cnt8 - 1;
   end
   assign tx_busy  = (busy_cnt != 0) || hold_busy;
   assign tx_busy8 = (busy_cnt8 != 0);

   // Character i of the line for a word of nib hex digits.
   function automatic logic [7:0] exp_char(input logic [63:0] v, input int nib, input int i);
      int d;
      if (i == nib)     return 8'h0D;
      if (i == nib + 1) return 8'h0A;
      d = int'((v >> (4 * (nib - 1 - i))) & 64'hF);
      if (d < 10) return 8'(48 + d);
      return 8'(65 + d - 10);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Call just after a negedge; returns one negedge later with valid dropped.
   task automatic request(input logic [31:0] v, input bit acc, input string nm);
      chk({nm, "_ready"}, {31'd0, ready}, {31'd0, acc});
      value = v;
      value_valid = 1'b1;
      if (acc) for (int i = 0; i < 10; i++) exp_q.push_back(exp_char({32'd0, v}, 8, i));
      else if (model_drop != 16'hFFFF) model_drop = model_drop + 16'd1;
      @(negedge clk);
      value_valid = 1'b0;
   endtask

   task automatic wait_lines(input int n, input int budget, input string nm);
      int b = 0;
      while (ld_seen < n && b < budget) begin
         @(negedge clk);
         b++;
      end
      chk({nm, "_lines"}, ld_seen, n);
   endtask

   task automatic wait_caps(input int n, input int budget);
      int b = 0;
      while (cap.size() < n && b < budget) begin
         @(negedge clk);
         b++;
      end
      chk("wait_bytes", cap.size(), n);
   endtask

   task automatic chk_line1(input string nm);
      chk({nm, "_count"}, cap.size(), 10);
      for (int i = 0; i < 10 && i < cap.size(); i++) chk({nm, "_byte"}, {24'd0, cap[i]}, {24'd0, L1[i]});
   endtask

   // Compare process: every byte the DUT starts must be the next one the model expects.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_start = 1'b0;
      end else begin
         if (tx_start) begin
            cap.push_back(tx_data);
            checks++;
            if (prev_start) begin
               errors++;
               $display("FAIL start_width: tx_start high two cycles at %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_start: byte %0h with no line pending at %0t", tx_data, $time);
            end else if (tx_data !== exp_q[0]) begin
               errors++;
               $display("FAIL byte: got %0h expected %0h at %0t", tx_data, exp_q[0], $time);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
         checks++;
         if (drop_cnt !== model_drop) begin
            errors++;
            $display("FAIL drop_cnt: got %0d expected %0d at %0t", drop_cnt, model_drop, $time);
         end
         if (line_done) ld_seen++;
         prev_start = tx_start;
         if (tx_start8) cap8.push_back(tx_data8);
         if (line_done8) ld8_seen++;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s;
      int b;
      rst = 1'b1;
      value = 32'h0;
      value_valid = 1'b0;
      value8 = 8'h0;
      value_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_line_done", {31'd0, line_done}, 32'd0);
      chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
      chk("rst_ready8", {31'd0, ready8}, 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: basic line and first-byte latency
      cap.delete();
      request(32'h1234ABCD, 1'b1, "t1");
      chk("t1_no_early_start", {31'd0, tx_start}, 32'd0);
      @(posedge clk);
      #2;
      chk("t1_first_start", {31'd0, tx_start}, 32'd1);
      chk("t1_first_data", {24'd0, tx_data}, 32'h31);
      @(negedge clk);
      wait_lines(1, 300, "t1");
      chk("t1_ready_after", {31'd0, ready}, 32'd1);
      chk_line1("t1");
      chk("t1_model_empty", exp_q.size(), 0);

      // 2: back-to-back request in the line_done cycle
      cap.delete();
      request(32'h00000000, 1'b1, "t2a");
      b = 0;
      while (!line_done && b < 300) begin
         @(negedge clk);
         b++;
      end
      chk("t2_line_done_seen", {31'd0, line_done}, 32'd1);
      request(32'hFFFFFFFF, 1'b1, "t2b");
      wait_lines(3, 300, "t2");
      chk("t2_count", cap.size(), 20);
      if (cap.size() == 20) begin
         chk("t2_b0", {24'd0, cap[0]}, 32'h30);
         chk("t2_b7", {24'd0, cap[7]}, 32'h30);
         chk("t2_b8", {24'd0, cap[8]}, 32'h0D);
         chk("t2_b10", {24'd0, cap[10]}, 32'h46);
         chk("t2_b17", {24'd0, cap[17]}, 32'h46);
         chk("t2_b19", {24'd0, cap[19]}, 32'h0A);
      end
      chk("t2_drop", {16'd0, drop_cnt}, 32'd0);

      // 3: requests during a line are dropped; value changes do not leak into the line
      cap.delete();
      request(32'h1234ABCD, 1'b1, "t3");
      wait_caps(2, 100);
      request(32'hDEADBEEF, 1'b0, "t3d1");
      @(negedge clk);
      request(32'h00000000, 1'b0, "t3d2");
      wait_caps(5, 100);
      request(32'hFFFF0000, 1'b0, "t3d3");
      value = 32'h55555555;
      wait_lines(4, 300, "t3");
      chk("t3_drop", {16'd0, drop_cnt}, 32'd3);
      chk_line1("t3");

      // 4: serializer busy before the first byte
      cap.delete();
      hold_busy = 1'b1;
      request(32'h1234ABCD, 1'b1, "t4");
      s = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start) s++;
      end
      chk("t4_stalled_starts", s, 0);
      hold_busy = 1'b0;
      wait_lines(5, 300, "t4");
      chk_line1("t4");

      // 5: reset during the fourth byte
      cap.delete();
      request(32'h1234ABCD, 1'b1, "t5");
      wait_caps(4, 100);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", {31'd0, ready}, 32'd1);
      chk("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("t5_rst_line_done", {31'd0, line_done}, 32'd0);
      chk("t5_rst_drop", {16'd0, drop_cnt}, 32'd0);
      exp_q.delete();
      model_drop = 16'h0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cap.delete();
      request(32'h1234ABCD, 1'b1, "t5b");
      wait_lines(6, 300, "t5");
      chk_line1("t5");

      // 6: 8-bit instance
      value8 = 8'h9E;
      value_valid8 = 1'b1;
      @(negedge clk);
      value_valid8 = 1'b0;
      b = 0;
      while (ld8_seen < 1 && b < 200) begin
         @(negedge clk);
         b++;
      end
      chk("t6_lines", ld8_seen, 1);
      chk("t6_count", cap8.size(), 4);
      if (cap8.size() == 4) begin
         chk("t6_b0", {24'd0, cap8[0]}, 32'h39);
         chk("t6_b1", {24'd0, cap8[1]}, 32'h45);
         chk("t6_b2", {24'd0, cap8[2]}, 32'h0D);
         chk("t6_b3", {24'd0, cap8[3]}, 32'h0A);
         for (int i = 0; i < 4; i++) chk("t6_model", {24'd0, cap8[i]}, {24'd0, exp_char(64'h9E, 2, i)});
      end
      chk("t6_ready", {31'd0, ready8}, 32'd1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
